// File: rtl/occ_lookup_arbiter_if.sv
// Bus bundle between the Extension requesters, the arbiter and the shared OccLookup engine.
// master = environment side (requesters + OccLookup), slave = arbiter.
interface occ_lookup_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned KLS_W = 34
);
    logic [N_REQ-1:0][KLS_W-1:0] req_k;
    logic [N_REQ-1:0][KLS_W-1:0] req_ks;
    logic [N_REQ-1:0]            req_lookup;
    logic [3:0][KLS_W-1:0]       resp_val_k;
    logic [3:0][KLS_W-1:0]       resp_val_ks;
    logic [N_REQ-1:0]            resp_valid;
    logic [KLS_W-1:0]            olu_k;
    logic [KLS_W-1:0]            olu_ks;
    logic                        olu_start;
    logic [3:0][KLS_W-1:0]       olu_val_k;
    logic [3:0][KLS_W-1:0]       olu_val_ks;
    logic                        olu_val_valid;

    modport master (
        output req_k, req_ks, req_lookup, olu_val_k, olu_val_ks, olu_val_valid,
        input  resp_val_k, resp_val_ks, resp_valid, olu_k, olu_ks, olu_start
    );

    modport slave (
        input  req_k, req_ks, req_lookup, olu_val_k, olu_val_ks, olu_val_valid,
        output resp_val_k, resp_val_ks, resp_valid, olu_k, olu_ks, olu_start
    );
endinterface

// File: rtl/occ_lookup_arbiter.sv
// Round-robin arbiter sharing one OccLookup engine between N_REQ Extension engines.
// One lookup is in flight at a time; each response is flagged only to its owner.
module occ_lookup_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned KLS_W = 34,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    occ_lookup_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     lookup_cnt
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                      state_q, state_d;
    logic [N_REQ-1:0]            pending_q, pending_d;
    logic [N_REQ-1:0][KLS_W-1:0] k_reg_q, k_reg_d;
    logic [N_REQ-1:0][KLS_W-1:0] ks_reg_q, ks_reg_d;
    logic [IDX_W-1:0]            owner_q, owner_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [KLS_W-1:0]            olu_k_q, olu_k_d;
    logic [KLS_W-1:0]            olu_ks_q, olu_ks_d;
    logic                        olu_start_q, olu_start_d;
    logic [3:0][KLS_W-1:0]       resp_val_k_q, resp_val_k_d;
    logic [3:0][KLS_W-1:0]       resp_val_ks_q, resp_val_ks_d;
    logic [N_REQ-1:0]            resp_valid_q, resp_valid_d;
    logic                        err_q, err_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic                        grant_vld;
    logic [IDX_W-1:0]            grant_idx;
    logic [IDX_W-1:0]            cand;
    logic                        owner_busy;

    // First pending requester at or after rr_ptr, searched cyclically.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IDX_W'((32'(rr_ptr_q) + off) % N_REQ);
            if (!grant_vld && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ownership is released on the response edge, so the owner may re-request there.
    assign owner_busy = (state_q == StWait) && !bus.olu_val_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_vld) state_d = StWait;
            StWait:  if (bus.olu_val_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pending_d     = pending_q;
        k_reg_d       = k_reg_q;
        ks_reg_d      = ks_reg_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        olu_k_d       = olu_k_q;
        olu_ks_d      = olu_ks_q;
        olu_start_d   = 1'b0;
        resp_val_k_d  = resp_val_k_q;
        resp_val_ks_d = resp_val_ks_q;
        resp_valid_d  = '0;
        err_d         = err_q;
        cnt_d         = cnt_q;

        if (state_q == StIdle) begin
            if (grant_vld) begin
                olu_k_d              = k_reg_q[grant_idx];
                olu_ks_d             = ks_reg_q[grant_idx];
                olu_start_d          = 1'b1;
                pending_d[grant_idx] = 1'b0;
                owner_d              = grant_idx;
                rr_ptr_d             = IDX_W'((32'(grant_idx) + 32'd1) % N_REQ);
            end
            if (bus.olu_val_valid) begin
                err_d = 1'b1;
            end
        end else if (bus.olu_val_valid) begin
            resp_val_k_d          = bus.olu_val_k;
            resp_val_ks_d         = bus.olu_val_ks;
            resp_valid_d[owner_q] = 1'b1;
            cnt_d                 = cnt_q + CNT_W'(1);
        end

        // A granted requester had pending_q set, so its own capture is rejected here.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req_lookup[i]) begin
                if (pending_q[i] || (owner_busy && owner_q == IDX_W'(i))) begin
                    err_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    k_reg_d[i]   = bus.req_k[i];
                    ks_reg_d[i]  = bus.req_ks[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            k_reg_q       <= '0;
            ks_reg_q      <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            olu_k_q       <= '0;
            olu_ks_q      <= '0;
            olu_start_q   <= 1'b0;
            resp_val_k_q  <= '0;
            resp_val_ks_q <= '0;
            resp_valid_q  <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            pending_q     <= pending_d;
            k_reg_q       <= k_reg_d;
            ks_reg_q      <= ks_reg_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            olu_k_q       <= olu_k_d;
            olu_ks_q      <= olu_ks_d;
            olu_start_q   <= olu_start_d;
            resp_val_k_q  <= resp_val_k_d;
            resp_val_ks_q <= resp_val_ks_d;
            resp_valid_q  <= resp_valid_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.olu_k       = olu_k_q;
    assign bus.olu_ks      = olu_ks_q;
    assign bus.olu_start   = olu_start_q;
    assign bus.resp_val_k  = resp_val_k_q;
    assign bus.resp_val_ks = resp_val_ks_q;
    assign bus.resp_valid  = resp_valid_q;
    assign busy            = (state_q != StIdle) | (|pending_q);
    assign err             = err_q;
    assign lookup_cnt      = cnt_q;

endmodule

// File: tb/tb_occ_lookup_arbiter.sv
// Bench for occ_lookup_arbiter: directed phases plus random traffic, checked by a
// transaction-level model feeding scoreboard queues that a negedge monitor drains.
module tb_occ_lookup_arbiter;
    localparam int N  = 4;
    localparam int KW = 34;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic          err;
    logic [CW-1:0] lookup_cnt;

    occ_lookup_arbiter_if #(.N_REQ(N), .KLS_W(KW)) bus ();

    occ_lookup_arbiter #(.N_REQ(N), .KLS_W(KW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .err        (err),
        .lookup_cnt (lookup_cnt)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    owner;
        logic [KW-1:0] k;
        logic [KW-1:0] ks;
    } exp_t;

    exp_t start_q[$];
    exp_t resp_q[$];
    int   grant_log[$];
    int   total = 0;
    int   bad   = 0;

    // OccLookup stand-in: deterministic occ values derived from k / k+s.
    function automatic logic [KW-1:0] fk(input logic [KW-1:0] x, input int c);
        return x * KW'(4) + KW'(c);
    endfunction
    function automatic logic [KW-1:0] fks(input logic [KW-1:0] x, input int c);
        return x + KW'(c * 1000 + 1);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: slots of pending requests, one in-flight lookup, cyclic pointer.
    logic [N-1:0]  m_pend, pend_old;
    logic [KW-1:0] m_k[N];
    logic [KW-1:0] m_ks[N];
    logic [KW-1:0] m_fk, m_fks;
    bit            m_busy, busy_old, m_err, m_gnt;
    int            m_owner, m_ptr, m_g, m_c;
    int unsigned   m_cnt;
    exp_t          me;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pend = '0; m_busy = 0; m_owner = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
            start_q.delete();
            resp_q.delete();
        end else begin
            pend_old = m_pend;
            busy_old = m_busy;
            m_gnt    = 0;
            m_g      = 0;
            if (!busy_old) begin
                if (bus.olu_val_valid) m_err = 1;
                for (int off = 0; off < N; off++) begin
                    m_c = (m_ptr + off) % N;
                    if (!m_gnt && pend_old[m_c]) begin
                        m_gnt = 1;
                        m_g   = m_c;
                    end
                end
                if (m_gnt) begin
                    m_pend[m_g] = 1'b0;
                    m_owner     = m_g;
                    m_ptr       = (m_g + 1) % N;
                    m_busy      = 1;
                    m_fk        = m_k[m_g];
                    m_fks       = m_ks[m_g];
                    me.owner    = 3'(m_g); me.k = m_fk; me.ks = m_fks;
                    start_q.push_back(me);
                end
            end else if (bus.olu_val_valid) begin
                me.owner = 3'(m_owner); me.k = m_fk; me.ks = m_fks;
                resp_q.push_back(me);
                m_cnt++;
                m_busy = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_lookup[i]) begin
                    if (pend_old[i] || (busy_old && !bus.olu_val_valid && m_owner == i)) begin
                        m_err = 1;
                    end else begin
                        m_pend[i] = 1'b1;
                        m_k[i]    = bus.req_k[i];
                        m_ks[i]   = bus.req_ks[i];
                    end
                end
            end
        end
    end

    // Monitor: drains the scoreboard whenever the DUT presents a start or a response.
    exp_t                es, er;
    bit                  lookup_open = 0;
    logic [N-1:0]        oh;
    logic [3:0][KW-1:0]  ev_k, ev_ks;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.olu_start) begin
                grant_log.push_back(int'(bus.olu_k[2:0]));
                chk(!lookup_open, "start_overlap", 160'(bus.olu_start), 160'(0));
                lookup_open = 1;
                if (start_q.size() == 0) begin
                    chk(0, "start_unexpected", 160'(bus.olu_k), 160'(0));
                end else begin
                    es = start_q.pop_front();
                    chk({bus.olu_k, bus.olu_ks} == {es.k, es.ks}, "start_k_ks",
                        160'({bus.olu_k, bus.olu_ks}), 160'({es.k, es.ks}));
                end
            end else if (start_q.size() != 0) begin
                chk(0, "start_missing", 160'(0), 160'(1));
                start_q.delete();
            end
            if (bus.olu_val_valid) lookup_open = 0;
            if (bus.resp_valid != '0) begin
                if (resp_q.size() == 0) begin
                    chk(0, "resp_unexpected", 160'(bus.resp_valid), 160'(0));
                end else begin
                    er = resp_q.pop_front();
                    oh = '0;
                    oh[er.owner] = 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        ev_k[c]  = fk(er.k, c);
                        ev_ks[c] = fks(er.ks, c);
                    end
                    chk(bus.resp_valid == oh, "resp_owner", 160'(bus.resp_valid), 160'(oh));
                    chk(bus.resp_val_k == ev_k, "resp_val_k", 160'(bus.resp_val_k), 160'(ev_k));
                    chk(bus.resp_val_ks == ev_ks, "resp_val_ks", 160'(bus.resp_val_ks),
                        160'(ev_ks));
                end
            end else if (resp_q.size() != 0) begin
                chk(0, "resp_missing", 160'(0), 160'(1));
                resp_q.delete();
            end
        end
    end

    // Driver: one clock step, including the OccLookup responder.
    bit            olu_busy    = 0;
    int            olu_wait    = 0;
    int            olu_lat     = 0;
    int            rereq0_left = 0;
    logic [KW-1:0] pk, pks;

    task automatic cycle();
        @(posedge clk);
        #1;
        bus.req_lookup    = '0;
        bus.olu_val_valid = 1'b0;
        if (bus.olu_start) begin
            olu_busy = 1;
            olu_wait = (olu_lat != 0) ? olu_lat : int'($urandom_range(1, 6));
            pk       = bus.olu_k;
            pks      = bus.olu_ks;
        end else if (olu_busy) begin
            olu_wait--;
            if (olu_wait == 0) begin
                olu_busy          = 0;
                bus.olu_val_valid = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    bus.olu_val_k[c]  = fk(pk, c);
                    bus.olu_val_ks[c] = fks(pks, c);
                end
                if (rereq0_left > 0 && pk[2:0] == 3'd0) begin
                    rereq0_left--;
                    bus.req_k[0]      = KW'({$urandom(), 3'd0});
                    bus.req_ks[0]     = KW'({$urandom(), 3'd0});
                    bus.req_lookup[0] = 1'b1;
                end
            end
        end
    endtask

    task automatic pulse(input int i, input logic [KW-1:0] k, input logic [KW-1:0] ks);
        bus.req_k[i]      = k;
        bus.req_ks[i]     = ks;
        bus.req_lookup[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        cycle();
        while ((busy || olu_busy) && n < 3000) begin
            cycle();
            n++;
        end
        cycle();
        if (busy || olu_busy) chk(0, "idle_timeout", 160'(busy), 160'(0));
    endtask

    function automatic int log_packed();
        int p;
        p = 0;
        foreach (grant_log[j]) p = p * 8 + grant_log[j];
        return p;
    endfunction

    initial begin
        rst_n             = 1'b0;
        bus.req_k         = '0;
        bus.req_ks        = '0;
        bus.req_lookup    = '0;
        bus.olu_val_k     = '0;
        bus.olu_val_ks    = '0;
        bus.olu_val_valid = 1'b0;
        cycle();
        cycle();
        chk(bus.olu_start == 1'b0, "rst_olu_start", 160'(bus.olu_start), 160'(0));
        chk(bus.resp_valid == '0, "rst_resp_valid", 160'(bus.resp_valid), 160'(0));
        chk({bus.olu_k, bus.olu_ks} == '0, "rst_olu_k", 160'({bus.olu_k, bus.olu_ks}), 160'(0));
        chk(bus.resp_val_k == '0, "rst_resp_val", 160'(bus.resp_val_k), 160'(0));
        chk({busy, err} == 2'b00, "rst_busy_err", 160'({busy, err}), 160'(0));
        chk(lookup_cnt == '0, "rst_cnt", 160'(lookup_cnt), 160'(0));
        rst_n = 1'b1;

        // Single lookup with a slow OccLookup.
        cycle();
        olu_lat = 32;
        pulse(2, KW'(5), KW'(9));
        cycle();
        chk(busy == 1'b1, "single_busy", 160'(busy), 160'(1));
        wait_idle();
        chk(lookup_cnt == CW'(1), "single_cnt", 160'(lookup_cnt), 160'(1));
        chk(err == 1'b0, "single_err", 160'(err), 160'(0));
        olu_lat = 0;

        // All four at once from a fresh pointer.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) pulse(i, KW'({$urandom(), 3'(i)}), KW'({$urandom(), 3'(i)}));
        wait_idle();
        chk(grant_log.size() == 4 && log_packed() == 'o0123, "contention_order",
            160'(log_packed()), 160'('o0123));
        chk(lookup_cnt == CW'(4), "contention_cnt", 160'(lookup_cnt), 160'(4));
        chk(err == 1'b0, "contention_err", 160'(err), 160'(0));

        // Requester 0 re-requests on its own responses; 3 must still get in.
        grant_log.delete();
        rereq0_left = 3;
        pulse(0, KW'({$urandom(), 3'd0}), KW'($urandom()));
        pulse(3, KW'({$urandom(), 3'd3}), KW'($urandom()));
        wait_idle();
        chk(grant_log.size() == 5 && log_packed() == 'o3000, "fair_order",
            160'(log_packed()), 160'('o3000));
        chk(err == 1'b0, "fair_err", 160'(err), 160'(0));

        // Duplicate request while pending keeps the first k.
        do_reset();
        pulse(0, KW'({32'h11, 3'd0}), KW'(7));
        pulse(1, KW'({32'hAA, 3'd1}), KW'(8));
        cycle();
        pulse(1, KW'({32'hBB, 3'd1}), KW'(9));
        wait_idle();
        chk(err == 1'b1, "dup_err", 160'(err), 160'(1));
        chk(lookup_cnt == CW'(2), "dup_cnt", 160'(lookup_cnt), 160'(2));

        // Spurious response while idle.
        do_reset();
        cycle();
        bus.olu_val_valid = 1'b1;
        cycle();
        cycle();
        chk(err == 1'b1, "spur_err", 160'(err), 160'(1));
        chk(bus.resp_valid == '0, "spur_no_resp", 160'(bus.resp_valid), 160'(0));
        chk(lookup_cnt == '0, "spur_cnt", 160'(lookup_cnt), 160'(0));

        // Reset while waiting; the late response must be dropped.
        do_reset();
        olu_lat = 20;
        pulse(1, KW'({32'h55, 3'd1}), KW'(3));
        for (int n = 0; n < 5; n++) cycle();
        chk(busy == 1'b1, "midwait_busy", 160'(busy), 160'(1));
        do_reset();
        chk({bus.olu_k, bus.olu_start, bus.resp_valid} == '0, "midwait_rst_out",
            160'({bus.olu_k, bus.olu_start, bus.resp_valid}), 160'(0));
        wait_idle();
        chk(err == 1'b1, "midwait_err", 160'(err), 160'(1));
        chk(lookup_cnt == '0, "midwait_cnt", 160'(lookup_cnt), 160'(0));
        olu_lat = 0;
        pulse(2, KW'({32'h77, 3'd2}), KW'(4));
        wait_idle();
        chk(lookup_cnt == CW'(1), "midwait_after_cnt", 160'(lookup_cnt), 160'(1));

        // Random traffic, including duplicates and re-requests on the response edge.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    pulse(i, KW'({$urandom(), 3'(i)}), KW'({$urandom(), 3'(i)}));
                end
            end
            cycle();
        end
        wait_idle();
        chk(lookup_cnt == CW'(m_cnt), "rand_cnt", 160'(lookup_cnt), 160'(m_cnt));
        chk(err == m_err, "rand_err", 160'(err), 160'(m_err));
        chk(busy == 1'b0, "rand_idle", 160'(busy), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
